// File: rtl/register_file_param_if.sv
// Datapath register-file bus: two read ports, two write ports, sweep control.
interface register_file_param_if #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] RA;
    logic [ADDR_W-1:0] RB;
    logic [WIDTH-1:0]  BusA;
    logic [WIDTH-1:0]  BusB;
    logic [ADDR_W-1:0] RW;
    logic [WIDTH-1:0]  BusW;
    logic              RegWr;
    logic [ADDR_W-1:0] RW2;
    logic [WIDTH-1:0]  BusW2;
    logic              RegWr2;
    logic              Clear;
    logic              Busy;

    modport master (
        output RA, RB, RW, BusW, RegWr, RW2, BusW2, RegWr2, Clear,
        input  BusA, BusB, Busy
    );

    modport slave (
        input  RA, RB, RW, BusW, RegWr, RW2, BusW2, RegWr2, Clear,
        output BusA, BusB, Busy
    );
endinterface

// File: rtl/register_file_param.sv
// Parametrised two-write/two-read register file with optional hardwired-zero
// register, optional write-to-read bypass and a one-entry-per-cycle clear sweep.
// All state changes on the falling edge of Clk.
module register_file_param #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned HAS_ZERO = 1,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned BYPASS   = 1
) (
    input logic                  Clk,
    input logic                  ResetL,
    register_file_param_if.slave bus
);

    // DEPTH may equal 2^ADDR_W, so the range check needs one extra bit.
    localparam logic [ADDR_W:0]   DepthW  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(ZERO_REG);

    typedef enum logic [0:0] {StIdle, StSweep} state_t;

    state_t            stateQ;
    logic [ADDR_W-1:0] cntQ;
    logic              busyQ;
    logic [WIDTH-1:0]  regFile [DEPTH];
    logic              bypassOn;
    logic [WIDTH-1:0]  busA;
    logic [WIDTH-1:0]  busB;

    // Address maps to a real, writable entry (in range and not the zero register).
    function automatic logic isLive(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DepthW) && !((HAS_ZERO != 0) && (addr == ZeroIdx));
    endfunction

    assign bypassOn = (BYPASS != 0) && (stateQ == StIdle) && ResetL;

    // Read port A: array value, overridden by forwarded write data (port 0 last, so it wins).
    always_comb begin
        busA = '0;
        if (isLive(bus.RA)) begin
            busA = regFile[bus.RA];
            if (bypassOn && bus.RegWr2 && (bus.RW2 == bus.RA)) busA = bus.BusW2;
            if (bypassOn && bus.RegWr && (bus.RW == bus.RA))   busA = bus.BusW;
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        busB = '0;
        if (isLive(bus.RB)) begin
            busB = regFile[bus.RB];
            if (bypassOn && bus.RegWr2 && (bus.RW2 == bus.RB)) busB = bus.BusW2;
            if (bypassOn && bus.RegWr && (bus.RW == bus.RB))   busB = bus.BusW;
        end
    end

    assign bus.BusA = busA;
    assign bus.BusB = busB;
    assign bus.Busy = busyQ;

    // Array writes, sweep sequencing and registered Busy; reset clears everything.
    always_ff @(negedge Clk) begin
        if (!ResetL) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regFile[i] <= '0;
            end
            stateQ <= StIdle;
            cntQ   <= '0;
            busyQ  <= 1'b0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    // Port 1 first so a same-address port 0 write overrides it.
                    if (bus.RegWr2 && isLive(bus.RW2)) regFile[bus.RW2] <= bus.BusW2;
                    if (bus.RegWr && isLive(bus.RW))   regFile[bus.RW]  <= bus.BusW;
                    if (bus.Clear) begin
                        stateQ <= StSweep;
                        cntQ   <= '0;
                        busyQ  <= 1'b1;
                    end
                end
                StSweep: begin
                    regFile[cntQ] <= '0;
                    if (cntQ == LastIdx) begin
                        stateQ <= StIdle;
                        cntQ   <= '0;
                        busyQ  <= 1'b0;
                    end else begin
                        cntQ <= cntQ + 1'b1;
                    end
                end
                default: begin
                    stateQ <= StIdle;
                    cntQ   <= '0;
                    busyQ  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: a default build (A: zero reg 31, bypass on) and
// an alternate build (B: 24 entries, no zero reg, no bypass) driven in parallel.
module tb_register_file_param;

    logic        Clk;
    logic        ResetL;
    logic [4:0]  RA, RB, RW, RW2;
    logic [63:0] BusW, BusW2;
    logic        RegWr, RegWr2, Clear;

    int nRun;
    int nFail;

    register_file_param_if #(.WIDTH(64), .ADDR_W(5)) ifA ();
    register_file_param_if #(.WIDTH(64), .ADDR_W(5)) ifB ();

    assign ifA.RA = RA;     assign ifB.RA = RA;
    assign ifA.RB = RB;     assign ifB.RB = RB;
    assign ifA.RW = RW;     assign ifB.RW = RW;
    assign ifA.RW2 = RW2;   assign ifB.RW2 = RW2;
    assign ifA.BusW = BusW; assign ifB.BusW = BusW;
    assign ifA.BusW2 = BusW2;   assign ifB.BusW2 = BusW2;
    assign ifA.RegWr = RegWr;   assign ifB.RegWr = RegWr;
    assign ifA.RegWr2 = RegWr2; assign ifB.RegWr2 = RegWr2;
    assign ifA.Clear = Clear;   assign ifB.Clear = Clear;

    register_file_param #(
        .WIDTH(64), .DEPTH(32), .ADDR_W(5), .HAS_ZERO(1), .ZERO_REG(31), .BYPASS(1)
    ) dutA (
        .Clk(Clk), .ResetL(ResetL), .bus(ifA.slave)
    );

    register_file_param #(
        .WIDTH(64), .DEPTH(24), .ADDR_W(5), .HAS_ZERO(0), .ZERO_REG(5), .BYPASS(0)
    ) dutB (
        .Clk(Clk), .ResetL(ResetL), .bus(ifB.slave)
    );

    initial Clk = 1'b1;
    always #5 Clk = ~Clk;

    // Reference model: k=0 is build A, k=1 is build B.
    logic [63:0] mem [2][32];
    int          left [2];   // sweep edges still to come; 0 means idle

    function automatic int dep(int k);
        return (k == 0) ? 32 : 24;
    endfunction

    function automatic bit okAddr(int k, int a);
        if (a >= dep(k)) return 1'b0;
        if (k == 0 && a == 31) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] expRead(int k, int a);
        if (!okAddr(k, a)) return 64'd0;
        if (k == 0 && left[0] == 0 && ResetL === 1'b1) begin
            if (RegWr && int'(RW) == a) return BusW;
            if (RegWr2 && int'(RW2) == a) return BusW2;
        end
        return mem[k][a];
    endfunction

    task automatic modelEdge();
        for (int k = 0; k < 2; k++) begin
            if (!ResetL) begin
                for (int i = 0; i < 32; i++) mem[k][i] = 64'd0;
                left[k] = 0;
            end else if (left[k] > 0) begin
                mem[k][dep(k) - left[k]] = 64'd0;
                left[k] = left[k] - 1;
            end else begin
                if (RegWr2 && okAddr(k, int'(RW2))) mem[k][RW2] = BusW2;
                if (RegWr && okAddr(k, int'(RW)))   mem[k][RW]  = BusW;
                if (Clear) left[k] = dep(k);
            end
        end
    endtask

    // Advance one active edge; inputs are stable at the edge, outputs sampled 1 later.
    task automatic step();
        @(negedge Clk);
        modelEdge();
        #1;
    endtask

    task automatic idleIn();
        RegWr = 1'b0; RegWr2 = 1'b0; Clear = 1'b0;
    endtask

    task automatic test_reset();
        ResetL = 1'b0; idleIn(); RA = '0; RB = '0; RW = '0; RW2 = '0; BusW = '0; BusW2 = '0;
        step();
        nRun++; if (ifA.Busy !== 1'b0) begin nFail++; $display("FAIL reset_busyA: got %b want 0", ifA.Busy); end
        nRun++; if (ifB.Busy !== 1'b0) begin nFail++; $display("FAIL reset_busyB: got %b want 0", ifB.Busy); end
        ResetL = 1'b1;
        for (int i = 0; i < 8; i++) begin
            RegWr = 1'b1; RW = 5'($urandom_range(0, 30)); BusW = {$urandom, $urandom} | 64'd1;
            step();
        end
        idleIn(); ResetL = 1'b0;
        step();
        ResetL = 1'b1;
        for (int i = 0; i < 32; i++) begin
            RA = 5'(i); RB = 5'(31 - i); #1;
            nRun++; if (ifA.BusA !== 64'd0) begin nFail++; $display("FAIL reset_clearA r%0d: got %h want 0", i, ifA.BusA); end
            nRun++; if (ifB.BusB !== 64'd0) begin nFail++; $display("FAIL reset_clearB r%0d: got %h want 0", 31 - i, ifB.BusB); end
        end
    endtask

    task automatic test_dual_write();
        RegWr = 1'b1; RegWr2 = 1'b1; RW = 5'd5; RW2 = 5'd5;
        BusW = 64'hAAAA; BusW2 = 64'h5555;
        step();
        idleIn(); RA = 5'd5; #1;
        nRun++; if (ifA.BusA !== 64'hAAAA) begin nFail++; $display("FAIL collideA: got %h want %h", ifA.BusA, 64'hAAAA); end
        nRun++; if (ifB.BusA !== 64'hAAAA) begin nFail++; $display("FAIL collideB: got %h want %h", ifB.BusA, 64'hAAAA); end
        RegWr = 1'b1; RegWr2 = 1'b1; RW = 5'd3; RW2 = 5'd7;
        BusW = 64'h3333_0000_1111; BusW2 = 64'h7777_0000_2222;
        step();
        idleIn(); RA = 5'd3; RB = 5'd7; #1;
        nRun++; if (ifA.BusA !== 64'h3333_0000_1111) begin nFail++; $display("FAIL sep_r3: got %h want %h", ifA.BusA, 64'h3333_0000_1111); end
        nRun++; if (ifA.BusB !== 64'h7777_0000_2222) begin nFail++; $display("FAIL sep_r7: got %h want %h", ifA.BusB, 64'h7777_0000_2222); end
    endtask

    task automatic test_random();
        logic [63:0] e;
        for (int it = 0; it < 60; it++) begin
            RA = 5'($urandom); RB = 5'($urandom); RW = 5'($urandom); RW2 = 5'($urandom);
            if (it % 4 == 0) RA = RW;
            if (it % 4 == 1) RB = RW2;
            BusW = {$urandom, $urandom}; BusW2 = {$urandom, $urandom};
            RegWr = 1'($urandom); RegWr2 = 1'($urandom); Clear = 1'b0;
            #1;
            for (int ph = 0; ph < 2; ph++) begin
                e = expRead(0, int'(RA));
                nRun++; if (ifA.BusA !== e) begin nFail++; $display("FAIL rand%0d.%0d A.BusA r%0d: got %h want %h", it, ph, RA, ifA.BusA, e); end
                e = expRead(0, int'(RB));
                nRun++; if (ifA.BusB !== e) begin nFail++; $display("FAIL rand%0d.%0d A.BusB r%0d: got %h want %h", it, ph, RB, ifA.BusB, e); end
                e = expRead(1, int'(RA));
                nRun++; if (ifB.BusA !== e) begin nFail++; $display("FAIL rand%0d.%0d B.BusA r%0d: got %h want %h", it, ph, RA, ifB.BusA, e); end
                e = expRead(1, int'(RB));
                nRun++; if (ifB.BusB !== e) begin nFail++; $display("FAIL rand%0d.%0d B.BusB r%0d: got %h want %h", it, ph, RB, ifB.BusB, e); end
                if (ph == 0) step();
            end
        end
        idleIn();
    endtask

    task automatic test_zero_reg();
        RegWr = 1'b1; RW = 5'd31; BusW = 64'hFFFF_FFFF_FFFF_FFFF;
        RegWr2 = 1'b1; RW2 = 5'd5; BusW2 = 64'hCAFE;
        RA = 5'd31; #1;
        nRun++; if (ifA.BusA !== 64'd0) begin nFail++; $display("FAIL zero_nobypass: got %h want 0", ifA.BusA); end
        step();
        idleIn(); RA = 5'd31; RB = 5'd5; #1;
        nRun++; if (ifA.BusA !== 64'd0) begin nFail++; $display("FAIL zeroA_r31: got %h want 0", ifA.BusA); end
        nRun++; if (ifB.BusA !== 64'd0) begin nFail++; $display("FAIL outrangeB_r31: got %h want 0", ifB.BusA); end
        nRun++; if (ifB.BusB !== 64'hCAFE) begin nFail++; $display("FAIL nozeroB_r5: got %h want %h", ifB.BusB, 64'hCAFE); end
        nRun++; if (ifA.BusB !== 64'hCAFE) begin nFail++; $display("FAIL A_r5: got %h want %h", ifA.BusB, 64'hCAFE); end
    endtask

    task automatic test_bypass();
        RegWr = 1'b1; RW = 5'd4; BusW = 64'd0;
        step();
        RW = 5'd4; RA = 5'd4; BusW = 64'h1234; #1;
        nRun++; if (ifA.BusA !== 64'h1234) begin nFail++; $display("FAIL bypassA: got %h want %h", ifA.BusA, 64'h1234); end
        nRun++; if (ifB.BusA !== 64'd0) begin nFail++; $display("FAIL nobypassB: got %h want 0", ifB.BusA); end
        step();
        idleIn(); #1;
        nRun++; if (ifA.BusA !== 64'h1234) begin nFail++; $display("FAIL postedgeA: got %h want %h", ifA.BusA, 64'h1234); end
        nRun++; if (ifB.BusA !== 64'h1234) begin nFail++; $display("FAIL postedgeB: got %h want %h", ifB.BusA, 64'h1234); end
    endtask

    task automatic test_sweep();
        int busyCnt;
        int guard;
        for (int i = 0; i < 16; i++) begin
            RegWr = 1'b1; RW = 5'(2 * i); BusW = 64'(2 * i + 1);
            RegWr2 = 1'b1; RW2 = 5'(2 * i + 1); BusW2 = 64'(2 * i + 2);
            step();
        end
        idleIn(); Clear = 1'b1;
        step();
        Clear = 1'b0;
        busyCnt = (ifA.Busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ifA.Busy === 1'b1) busyCnt++;
            nRun++; if (ifB.Busy !== (left[1] > 0)) begin nFail++; $display("FAIL sweep_busyB e%0d: got %b want %b", i, ifB.Busy, left[1] > 0); end
        end
        RA = 5'd9; RB = 5'd20; #1;
        nRun++; if (ifA.BusA !== 64'd0) begin nFail++; $display("FAIL mid_r9: got %h want 0", ifA.BusA); end
        nRun++; if (ifA.BusB !== 64'd21) begin nFail++; $display("FAIL mid_r20: got %h want 21", ifA.BusB); end
        RegWr = 1'b1; RW = 5'd20; BusW = 64'hDEAD; #1;
        nRun++; if (ifA.BusB !== 64'd21) begin nFail++; $display("FAIL sweep_nobypass: got %h want 21", ifA.BusB); end
        step();
        if (ifA.Busy === 1'b1) busyCnt++;
        RegWr = 1'b0; #1;
        nRun++; if (ifA.BusB !== 64'd21) begin nFail++; $display("FAIL sweep_wrdrop: got %h want 21", ifA.BusB); end
        guard = 0;
        while (ifA.Busy === 1'b1 && guard < 100) begin
            step();
            guard++;
            if (ifA.Busy === 1'b1) busyCnt++;
            nRun++; if (ifA.Busy !== (left[0] > 0)) begin nFail++; $display("FAIL sweep_busyA: got %b want %b", ifA.Busy, left[0] > 0); end
        end
        nRun++; if (guard >= 100) begin nFail++; $display("FAIL sweep_timeout: got busy after %0d edges want idle", guard); end
        nRun++; if (busyCnt != 32) begin nFail++; $display("FAIL sweep_len: got %0d want 32", busyCnt); end
        for (int i = 0; i < 32; i++) begin
            RA = 5'(i); RB = 5'(i); #1;
            nRun++; if (ifA.BusA !== 64'd0) begin nFail++; $display("FAIL swept_A r%0d: got %h want 0", i, ifA.BusA); end
            nRun++; if (ifB.BusB !== 64'd0) begin nFail++; $display("FAIL swept_B r%0d: got %h want 0", i, ifB.BusB); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [63:0] v;
        for (int i = 0; i < 6; i++) begin
            RegWr = 1'b1; RW = 5'($urandom_range(0, 23)); BusW = {$urandom, $urandom} | 64'd1;
            step();
        end
        idleIn(); Clear = 1'b1;
        step();
        Clear = 1'b0;
        for (int i = 0; i < 5; i++) step();
        ResetL = 1'b0;
        step();
        nRun++; if (ifA.Busy !== 1'b0) begin nFail++; $display("FAIL midrst_busyA: got %b want 0", ifA.Busy); end
        nRun++; if (ifB.Busy !== 1'b0) begin nFail++; $display("FAIL midrst_busyB: got %b want 0", ifB.Busy); end
        for (int i = 0; i < 32; i++) begin
            RA = 5'(i); RB = 5'(i); #1;
            nRun++; if (ifA.BusA !== 64'd0) begin nFail++; $display("FAIL midrst_A r%0d: got %h want 0", i, ifA.BusA); end
            nRun++; if (ifB.BusB !== expRead(1, i)) begin nFail++; $display("FAIL midrst_B r%0d: got %h want 0", i, ifB.BusB); end
        end
        ResetL = 1'b1;
        v = {$urandom, $urandom};
        RegWr = 1'b1; RW = 5'd2; BusW = v;
        step();
        idleIn(); RA = 5'd2; RB = 5'd2; #1;
        nRun++; if (ifA.BusA !== v) begin nFail++; $display("FAIL postrst_wrA: got %h want %h", ifA.BusA, v); end
        nRun++; if (ifB.BusB !== v) begin nFail++; $display("FAIL postrst_wrB: got %h want %h", ifB.BusB, v); end
        nRun++; if (ifA.Busy !== 1'b0) begin nFail++; $display("FAIL postrst_busy: got %b want 0", ifA.Busy); end
    endtask

    initial begin
        nRun = 0; nFail = 0;
        left[0] = 0; left[1] = 0;
        test_reset();
        test_dual_write();
        test_random();
        test_zero_reg();
        test_bypass();
        test_sweep();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 want finish");
        $fatal(1, "timeout");
    end

endmodule
